button_event_ctrl: RTL
======================

# button_event_ctrl

Turns the debounced button levels from the per-key `debounce` instances into a stream of timestamp-free button events: PRESS, LONG, REPEAT and RELEASE. Each button has its own hold-timer state machine. Pending events from all buttons share one event FIFO through a round-robin arbiter. A valid/ready port feeds the FIFO to the application FSM (game or menu logic), so downstream code never deals with edges or hold timing.

## Interface
Parameters:
- `NUM_BUTTONS`, 4: number of debounced inputs, range 2..16.
- `LONG_COUNTS`, 50_000_000: hold cycles from PRESS to LONG (1 s at 50 MHz); must be ≥ 2.
- `REPEAT_COUNTS`, 10_000_000: cycles between REPEAT events after LONG; 0 disables REPEAT.
- `FIFO_DEPTH`, 4: event FIFO entries, power of two, ≥ 2.

Ports:
- `clk`, in, 1: system clock. One clock; reset is asynchronous and active-low.
- `rst_n`, in, 1: asynchronous active-low reset.
- `btn_level`, in, `NUM_BUTTONS`: debounced levels, 1 = pressed. Already synchronous to `clk`.
- `evt_valid`, out, 1: FIFO head valid.
- `evt_ready`, in, 1: consumer accepts the head.
- `evt_id`, out, `$clog2(NUM_BUTTONS)`: button index of the head event.
- `evt_type`, out, 2: PRESS=0, LONG=1, REPEAT=2, RELEASE=3.
- `overflow`, out, 1: sticky flag, set when an event is dropped.
- `ovf_clear`, in, 1: synchronous clear of `overflow`.

## Operation
- **Per-button FSM** has three states: IDLE, PRESSED and HELD. Each button has a hold counter of width `$clog2(max(LONG_COUNTS,REPEAT_COUNTS)+1)` and a registered `prev` level.
  - IDLE → PRESSED when `btn_level` = 1 and `prev` = 0. Raises PRESS and clears the counter.
  - PRESSED: the counter increments each cycle. When it reaches `LONG_COUNTS`-1, the FSM raises LONG, moves to HELD and clears the counter.
  - HELD: if `REPEAT_COUNTS` ≠ 0 and the counter reaches `REPEAT_COUNTS`-1, the FSM raises REPEAT and clears the counter. The counter saturates otherwise.
  - From PRESSED or HELD, a falling level raises RELEASE, moves to IDLE and clears the counter.
  - Release coincident with a LONG or REPEAT terminal count: RELEASE wins and no LONG or REPEAT is raised.
- **Pending slot** is one per button, holding a valid bit and a type. A newly raised event while the slot is still valid is dropped and `overflow` is set. The older event is kept.
- **Arbiter**: each cycle, if the FIFO will accept a write, grant one valid slot in round-robin order. The pointer starts after the last granted index and resets to 0. The granted slot is cleared and written to the FIFO as {id, type}.
  - A slot granted in the same cycle it is refilled takes the new event, with no drop.
- **FIFO** is first-in first-out. The head drives `evt_valid`, `evt_id` and `evt_type`. A pop occurs on `evt_valid & evt_ready`.
  - When full, a write is accepted only if a pop happens in the same cycle.
  - When empty, there is no bypass; a write becomes visible the next cycle.
  - `evt_id` and `evt_type` are held stable while `evt_valid` and not `evt_ready`.
- **`overflow`**: a set in the same cycle as `ovf_clear` wins.

## Timing
- Reset values:
  - all FSMs IDLE, `prev` = 0, counters 0, slots invalid;
  - FIFO empty, arbiter pointer 0;
  - `evt_valid` = 0, `evt_id` = 0, `evt_type` = 0, `overflow` = 0.
- Latency with an uncontended, non-full FIFO: level change sampled at edge k → slot valid after k → FIFO write at k+1 → `evt_valid` high after edge k+1 (2 cycles).
- LONG is raised exactly `LONG_COUNTS` cycles after PRESS is raised. Successive REPEATs are `REPEAT_COUNTS` cycles apart, with the first one `REPEAT_COUNTS` cycles after LONG.
- A button held through reset deassertion produces no PRESS: `prev` is 0, but the FSM only leaves IDLE on a rise observed after reset. An implementation note is required here: `prev` loads the input one cycle after reset and the FSM ignores the first post-reset cycle.
- Reset asserted mid-operation clears everything immediately. Queued events are lost and no RELEASE is emitted.
- Throughput: at most one FIFO write and one pop per cycle.

## Structure
- Package `button_event_pkg`:
  - `evt_type_t` enum (PRESS, LONG, REPEAT, RELEASE);
  - `btn_state_t` enum (IDLE, PRESSED, HELD);
  - packed `evt_t` {id, type}.
- Sub-module `event_fifo`: synchronous FIFO of `evt_t`, parameterised by depth. Signals: push/full and pop/empty, plus a count output.
- The per-button FSMs and the arbiter live in the top module via a generate loop.

## Test plan
Parameters for all scenarios: NUM_BUTTONS=4, LONG_COUNTS=20, REPEAT_COUNTS=5, FIFO_DEPTH=4, `evt_ready` = 1 unless stated.

- **Short tap:** button 2 high for 10 cycles → {2,PRESS} 2 cycles after the rise, then {2,RELEASE}; no LONG.
- **Long hold:** button 1 high for 32 cycles → PRESS, LONG 20 cycles later, REPEATs at +5 and +10, then RELEASE.
- **Simultaneous press:** buttons 0–3 rise on the same edge → four PRESS events on four consecutive cycles with ids 0,1,2,3; a second simultaneous burst is ordered by the rotated pointer.
- **Backpressure:** `evt_ready` = 0 while six events occur → FIFO holds 4, the head stays stable, `overflow` = 1 after the slot collision; `ovf_clear` → 0.
- **Release at terminal count:** release exactly on the LONG cycle → RELEASE only. Reset asserted mid-hold → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/button_event_pkg.sv
// Shared types for the button event controller: event kinds, per-button
// hold states and the packed {id, type} word stored in the event FIFO.
package button_event_pkg;

  // Event kinds as seen by the consumer on evt_type
  typedef enum logic [1:0] {
    PRESS   = 2'd0,
    LONG    = 2'd1,
    REPEAT  = 2'd2,
    RELEASE = 2'd3
  } evt_type_t;

  // Per-button hold-timer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  // Wide enough for the largest supported button count (16)
  localparam int EVT_ID_W = 4;

  typedef struct packed {
    logic [EVT_ID_W-1:0] id;
    evt_type_t           etype;
  } evt_t;

  function automatic int max_count(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Hold counter must be able to reach the larger of the two terminal counts
  function automatic int counter_width(input int long_counts, input int repeat_counts);
    return $clog2(max_count(long_counts, repeat_counts) + 1);
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO of button events. No bypass: a write into an empty FIFO
// becomes visible on the next cycle. A write while full is taken only when a
// pop happens in the same cycle.
module event_fifo
  import button_event_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  evt_t                   push_data,
  output logic                   full,
  input  logic                   pop,
  output evt_t                   pop_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  evt_t         mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head reads as zero while empty so the outputs match their reset values
  assign pop_data = empty ? evt_t'('0) : mem[rd_ptr[AW-1:0]];

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Read and write pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Converts debounced button levels into PRESS / LONG / REPEAT / RELEASE
// events. Each button runs its own hold-timer FSM and owns a one-entry pending
// slot; a round-robin arbiter moves pending slots into a shared event FIFO
// which the consumer drains through a valid/ready port.
module button_event_ctrl
  import button_event_pkg::*;
#(
  parameter int NUM_BUTTONS   = 4,
  parameter int LONG_COUNTS   = 50_000_000,
  parameter int REPEAT_COUNTS = 10_000_000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_BUTTONS-1:0]         btn_level,
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [$clog2(NUM_BUTTONS)-1:0] evt_id,
  output logic [1:0]                     evt_type,
  output logic                           overflow,
  input  logic                           ovf_clear
);

  localparam int ID_W    = $clog2(NUM_BUTTONS);
  localparam int CNT_W   = counter_width(LONG_COUNTS, REPEAT_COUNTS);
  localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam bit REPEAT_EN = (REPEAT_COUNTS != 0);
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_COUNTS - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = REPEAT_EN ? CNT_W'(REPEAT_COUNTS - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic                         armed;
  logic [NUM_BUTTONS-1:0]       slot_valid;
  logic [NUM_BUTTONS-1:0][1:0]  slot_type_vec;
  logic [NUM_BUTTONS-1:0]       drop;
  logic [NUM_BUTTONS-1:0]       grant;
  logic [ID_W-1:0]              grant_idx;
  logic                         grant_found;
  logic [ID_W-1:0]              rr_ptr;

  logic                         can_write;
  logic                         fifo_pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [FCNT_W-1:0]            fifo_count;
  evt_t                         push_data;
  evt_t                         head;

  // First cycle after reset only loads prev, so a button held through reset
  // is seen as already high and produces no PRESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    btn_state_t        state;
    btn_state_t        state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic              prev;
    logic              raise;
    evt_type_t         raise_kind;
    logic              sv;
    evt_type_t         st;

    // Previous level for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev <= 1'b0;
      end else begin
        prev <= btn_level[i];
      end
    end

    // Hold-timer state register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
      end
    end

    // Next state and raised event; a release always beats a terminal count
    always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      raise      = 1'b0;
      raise_kind = PRESS;
      if (armed) begin
        case (state)
          IDLE: begin
            if (btn_level[i] && !prev) begin
              state_nx   = PRESSED;
              cnt_nx     = '0;
              raise      = 1'b1;
              raise_kind = PRESS;
            end
          end
          PRESSED: begin
            if (!btn_level[i]) begin
              state_nx   = IDLE;
              cnt_nx     = '0;
              raise      = 1'b1;
              raise_kind = RELEASE;
            end else if (cnt == LONG_TC) begin
              state_nx   = HELD;
              cnt_nx     = '0;
              raise      = 1'b1;
              raise_kind = LONG;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
          HELD: begin
            if (!btn_level[i]) begin
              state_nx   = IDLE;
              cnt_nx     = '0;
              raise      = 1'b1;
              raise_kind = RELEASE;
            end else if (REPEAT_EN && (cnt == REPEAT_TC)) begin
              cnt_nx     = '0;
              raise      = 1'b1;
              raise_kind = REPEAT;
            end else if (cnt != CNT_MAX) begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
          default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        endcase
      end
    end

    // Pending slot: a slot granted this cycle may be refilled without loss,
    // otherwise a new event into a full slot is dropped and the old one kept
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sv <= 1'b0;
        st <= PRESS;
      end else if (raise && (!sv || grant[i])) begin
        sv <= 1'b1;
        st <= raise_kind;
      end else if (grant[i]) begin
        sv <= 1'b0;
      end
    end

    assign drop[i]          = raise & sv & ~grant[i];
    assign slot_valid[i]    = sv;
    assign slot_type_vec[i] = st;
  end

  assign fifo_pop  = evt_ready & ~fifo_empty;
  assign can_write = ~fifo_full | fifo_pop;

  // Round-robin search starting at rr_ptr for the first pending slot
  always_comb begin
    logic [ID_W:0] idx;
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    idx         = '0;
    if (can_write) begin
      for (int off = 0; off < NUM_BUTTONS; off++) begin
        idx = {1'b0, rr_ptr} + (ID_W+1)'(off);
        if (idx >= (ID_W+1)'(NUM_BUTTONS)) begin
          idx = idx - (ID_W+1)'(NUM_BUTTONS);
        end
        if (!grant_found && slot_valid[idx[ID_W-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = idx[ID_W-1:0];
        end
      end
    end
    if (grant_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Pointer moves to the index after the last grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_found) begin
      rr_ptr <= (grant_idx == ID_W'(NUM_BUTTONS - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  assign push_data.id    = EVT_ID_W'(grant_idx);
  assign push_data.etype = evt_type_t'(slot_type_vec[grant_idx]);

  event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant_found),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign evt_valid = (fifo_count != '0);
  assign evt_id    = ID_W'(head.id);
  assign evt_type  = head.etype;

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (|drop) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

endmodule
